// File: rtl/trail_grid_pkg.sv
// Shared constants, cell codes, colours and FSM encoding for the trail grid
// renderer and its cell RAM.
package trail_grid_pkg;

  localparam logic [6:0] GRID_W       = 7'd80;
  localparam logic [6:0] GRID_H       = 7'd60;
  localparam logic [6:0] BORDER_CELLS = 7'd2;
  localparam int         CELL_SHIFT   = 3;
  localparam int         GRID_CELLS   = 4800;
  localparam int         ADDR_W       = 13;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 13'd4799;

  localparam logic [9:0] PIX_W     = 10'd640;
  localparam logic [9:0] PIX_H     = 10'd480;
  localparam logic [9:0] BORDER_PX = 10'd16;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_P1    = 2'd1;
  localparam logic [1:0] CELL_P2    = 2'd2;
  localparam logic [1:0] CELL_WALL  = 2'd3;

  localparam logic [23:0] COLOUR_BLACK  = 24'h000000;
  localparam logic [23:0] COLOUR_BORDER = 24'hFF0000;
  localparam logic [23:0] COLOUR_P1     = 24'hFFFF00;
  localparam logic [23:0] COLOUR_P2     = 24'h00FFFF;
  localparam logic [23:0] COLOUR_WALL   = 24'hFFFFFF;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // y*80 + x built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] cx,
                                                  input logic [6:0] cy);
    return {cy, 6'b0} + {2'b00, cy, 4'b0} + {6'b0, cx};
  endfunction

  function automatic logic [23:0] cell_colour(input logic [1:0] code);
    case (code)
      CELL_P1:   return COLOUR_P1;
      CELL_P2:   return COLOUR_P2;
      CELL_WALL: return COLOUR_WALL;
      default:   return COLOUR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/trail_grid_ram.sv
// Simple dual-port 4800x2 cell store: port A read-only for the pixel path,
// port B read/write for the check and clear path. Reads return the old value.
module trail_grid_ram
  import trail_grid_pkg::*;
(
  input  logic              VGA_CLK,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [1:0]        a_data,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [1:0]        b_din,
  output logic [1:0]        b_data
);

  logic [1:0] mem [0:GRID_CELLS-1];
  logic [1:0] a_data_reg;
  logic [1:0] b_data_reg;

  always_ff @(posedge VGA_CLK) begin
    a_data_reg <= mem[a_addr];
  end

  always_ff @(posedge VGA_CLK) begin
    if (b_we) begin
      mem[b_addr] <= b_din;
    end
    b_data_reg <= mem[b_addr];
  end

  assign a_data = a_data_reg;
  assign b_data = b_data_reg;

endmodule

// File: rtl/trail_grid_renderer.sv
// Renders the 80x60 trail grid for the VGA pixel stream and arbitrates
// collision-checked trail writes from the players.
module trail_grid_renderer
  import trail_grid_pkg::*;
(
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       reiniciar,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic       wr_en,
  input  logic [6:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [1:0] wr_val,
  output logic       wr_ready,
  output logic       hit,
  output logic [1:0] hit_owner,
  output logic       clearing,
  output logic [7:0] OUT_R,
  output logic [7:0] OUT_G,
  output logic [7:0] OUT_B
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
  logic [6:0]        req_x_reg, req_x_next;
  logic [5:0]        req_y_reg, req_y_next;
  logic [1:0]        req_val_reg, req_val_next;
  logic              hit_reg, hit_next;
  logic [1:0]        hit_owner_reg, hit_owner_next;

  logic [ADDR_W-1:0] ram_b_addr;
  logic              ram_b_we;
  logic [1:0]        ram_b_din;
  logic [1:0]        ram_b_data;

  logic [ADDR_W-1:0] pix_addr;
  logic              pix_inactive, pix_border;
  logic [1:0]        pix_cell;
  logic              inactive_reg, border_reg, blank_reg;
  logic [23:0]       colour_reg, colour_next;

  logic              wr_legal;
  logic              tgt_bad;

  trail_grid_ram u_ram (
    .VGA_CLK (VGA_CLK),
    .a_addr  (pix_addr),
    .a_data  (pix_cell),
    .b_addr  (ram_b_addr),
    .b_we    (ram_b_we),
    .b_din   (ram_b_din),
    .b_data  (ram_b_data)
  );

  // Stage 1 is the RAM's registered read alongside the flags; stage 2 is colour.
  assign pix_addr     = cell_addr(next_x[9:CELL_SHIFT], next_y[9:CELL_SHIFT]);
  assign pix_inactive = (next_x >= PIX_W) || (next_y >= PIX_H);
  assign pix_border   = (next_x < BORDER_PX) || (next_x >= PIX_W - BORDER_PX) ||
                        (next_y < BORDER_PX) || (next_y >= PIX_H - BORDER_PX);

  always_ff @(posedge VGA_CLK) begin
    if (!reset) begin
      inactive_reg <= 1'b1;
      border_reg   <= 1'b0;
      blank_reg    <= 1'b1;
      colour_reg   <= COLOUR_BLACK;
    end else begin
      inactive_reg <= pix_inactive;
      border_reg   <= pix_border;
      blank_reg    <= clearing;
      colour_reg   <= colour_next;
    end
  end

  always_comb begin
    colour_next = COLOUR_BLACK;
    if (inactive_reg) begin
      colour_next = COLOUR_BLACK;
    end else if (border_reg) begin
      colour_next = COLOUR_BORDER;
    end else if (blank_reg) begin
      colour_next = COLOUR_BLACK;
    end else begin
      colour_next = cell_colour(pix_cell);
    end
  end

  assign OUT_R = colour_reg[23:16];
  assign OUT_G = colour_reg[15:8];
  assign OUT_B = colour_reg[7:0];

  assign wr_legal = (wr_val == CELL_P1) || (wr_val == CELL_P2);

  // Walls are never stored; off-grid and ring targets are rejected by position.
  assign tgt_bad = (req_x_reg >= GRID_W) || ({1'b0, req_y_reg} >= GRID_H) ||
                   (req_x_reg < BORDER_CELLS) ||
                   (req_x_reg >= GRID_W - BORDER_CELLS) ||
                   ({1'b0, req_y_reg} < BORDER_CELLS) ||
                   ({1'b0, req_y_reg} >= GRID_H - BORDER_CELLS);

  always_ff @(posedge VGA_CLK) begin
    if (!reset) begin
      state_reg     <= ST_CLEAR;
      clr_addr_reg  <= '0;
      req_x_reg     <= '0;
      req_y_reg     <= '0;
      req_val_reg   <= CELL_EMPTY;
      hit_reg       <= 1'b0;
      hit_owner_reg <= CELL_EMPTY;
    end else begin
      state_reg     <= state_next;
      clr_addr_reg  <= clr_addr_next;
      req_x_reg     <= req_x_next;
      req_y_reg     <= req_y_next;
      req_val_reg   <= req_val_next;
      hit_reg       <= hit_next;
      hit_owner_reg <= hit_owner_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_addr_next  = clr_addr_reg;
    req_x_next     = req_x_reg;
    req_y_next     = req_y_reg;
    req_val_next   = req_val_reg;
    hit_next       = 1'b0;
    hit_owner_next = hit_owner_reg;
    ram_b_addr     = clr_addr_reg;
    ram_b_we       = 1'b0;
    ram_b_din      = CELL_EMPTY;

    case (state_reg)
      ST_CLEAR: begin
        ram_b_we = 1'b1;
        if (reiniciar) begin
          clr_addr_next = '0;
        end else if (clr_addr_reg == LAST_ADDR) begin
          clr_addr_next = '0;
          state_next    = ST_IDLE;
        end else begin
          clr_addr_next = clr_addr_reg + 1'b1;
        end
      end

      ST_IDLE: begin
        ram_b_addr = cell_addr(wr_x, {1'b0, wr_y});
        if (reiniciar) begin
          clr_addr_next = '0;
          state_next    = ST_CLEAR;
        end else if (wr_en && wr_legal) begin
          req_x_next   = wr_x;
          req_y_next   = wr_y;
          req_val_next = wr_val;
          state_next   = ST_CHECK;
        end
      end

      ST_CHECK: begin
        ram_b_addr = cell_addr(req_x_reg, {1'b0, req_y_reg});
        ram_b_din  = req_val_reg;
        if (reiniciar) begin
          clr_addr_next = '0;
          state_next    = ST_CLEAR;
        end else begin
          state_next = ST_IDLE;
          if (tgt_bad) begin
            hit_next       = 1'b1;
            hit_owner_next = CELL_WALL;
          end else if (ram_b_data != CELL_EMPTY) begin
            hit_next       = 1'b1;
            hit_owner_next = ram_b_data;
          end else begin
            ram_b_we       = 1'b1;
            hit_owner_next = CELL_EMPTY;
          end
        end
      end

      default: begin
        clr_addr_next = '0;
        state_next    = ST_CLEAR;
      end
    endcase
  end

  assign wr_ready  = (state_reg == ST_IDLE);
  assign clearing  = (state_reg == ST_CLEAR);
  assign hit       = hit_reg;
  assign hit_owner = hit_owner_reg;

endmodule
